// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter state encoding and frame width.
// Also imported by the spi_receiver testbench.
package spi_pkg;

   localparam int SPI_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      DONE,
      HOLD,
      GAP
   } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period generator: while enabled, toggles sck every CLK_DIV cycles and
// raises rise/fall strobes in the cycle before the corresponding sck edge.
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int            CW   = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          tick;

   assign tick     = en && (cnt == LAST);
   assign rise_stb = tick && !sck;
   assign fall_stb = tick && sck;

   // Dropping the enable clears the phase, so every frame starts with a full low half-period.
   always_ff @(posedge clk) begin
      if (!rst || !en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (tick) begin
         cnt <= '0;
         sck <= ~sck;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_transmitter.sv
// SPI mode-0 master, MSB first, valid/ready byte input with back-to-back framing.
// Define SPI_TX_RX_CAPTURE_EN to capture spi_miso into rx_data/rx_valid.
module spi_transmitter
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                spi_sck,
   output logic                spi_mosi,
   output logic                spi_cs,
   input  logic                spi_miso,
   output logic                busy,
   output logic                tx_done,
   output logic [SPI_BITS-1:0] rx_data,
   output logic                rx_valid
);

   localparam int            CW         = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST_PHASE = CW'(CLK_DIV - 1);
   localparam int            BW         = $clog2(SPI_BITS);
   localparam logic [BW-1:0] LAST_BIT   = BW'(SPI_BITS - 1);

   state_t              state, state_next;
   logic [SPI_BITS-1:0] shift_reg;
   logic [BW-1:0]       bit_cnt;
   logic [CW-1:0]       phase_cnt;
   logic                accept;
   logic                rise_stb, fall_stb;

   assign accept   = tx_valid && tx_ready;
   assign spi_mosi = shift_reg[SPI_BITS-1];

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (state == SHIFT),
      .sck      (spi_sck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (fall_stb && bit_cnt == LAST_BIT) state_next = DONE;
         DONE:    state_next = accept ? SHIFT : HOLD;
         HOLD:    if (phase_cnt == LAST_PHASE) state_next = GAP;
         GAP:     if (phase_cnt == LAST_PHASE) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up exactly with the state register.
   // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         spi_cs    <= 1'b1;
         tx_ready  <= 1'b0;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         phase_cnt <= '0;
      end else begin
         state    <= state_next;
         spi_cs   <= (state_next == IDLE) || (state_next == GAP);
         tx_ready <= (state_next == IDLE) || (state_next == DONE);
         busy     <= (state_next != IDLE);
         tx_done  <= (state_next == DONE);

         if (accept) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
         end else if (state == SHIFT && fall_stb) begin
            bit_cnt <= bit_cnt + BW'(1);
            // Bit 0 stays on mosi through DONE/HOLD rather than shifting in a filler zero.
            if (bit_cnt != LAST_BIT) shift_reg <= shift_reg << 1;
         end

         if (state_next != state)                 phase_cnt <= '0;
         else if (state == HOLD || state == GAP)  phase_cnt <= phase_cnt + CW'(1);
      end
   end

`ifdef SPI_TX_RX_CAPTURE_EN
   logic [SPI_BITS-1:0] rx_shift;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         if (state == SHIFT && rise_stb) rx_shift <= {rx_shift[SPI_BITS-2:0], spi_miso};
         if (state_next == DONE)         rx_data  <= rx_shift;
         rx_valid <= (state_next == DONE);
      end
   end
`else
   logic unused_rx;

   assign unused_rx = spi_miso ^ rise_stb;
   assign rx_data   = '0;
   assign rx_valid  = 1'b0;
`endif

endmodule
